// File: rtl/loop_sequencer.sv
// rtl/loop_sequencer.sv - loop control stage driving a WIDTH-bit iteration counter
//
// Purpose: accepts a start request with an iteration limit, clears the
// downstream counter, offers one step per handshake while advancing the
// counter, and pulses done once the last step has been accepted.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       begin a loop (sampled in IDLE only)
//   limit       iteration count, latched on accepted start
//   abort       cancel an active loop (CLEAR or RUN)
//   step_ready  downstream accepts the current step
//   count       current value of the iteration counter
//   cnt_reset   counter synchronous clear
//   cnt_enable  counter count enable
//   step_valid  step offered downstream
//   busy        high in CLEAR and RUN
//   done        one-cycle completion pulse
//   step_last   (LOOP_SEQUENCER_LAST_EN only) marks the final step
//
// Optional feature macro: LOOP_SEQUENCER_LAST_EN

module loop_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             abort,
    input  logic             step_ready,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic             step_valid,
    output logic             busy,
    output logic             done
`ifdef LOOP_SEQUENCER_LAST_EN
    ,
    output logic             step_last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] limit_q;
    logic             last_step;

    // Only meaningful in RUN, where limit_q is at least 1, so the
    // decrement never underflows in a cycle where it matters.
    assign last_step = (count == (limit_q - ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            limit_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                limit_q <= limit;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_reset  = 1'b0;
        cnt_enable = 1'b0;
        step_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end

            S_CLEAR: begin
                cnt_reset = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_next = S_IDLE;
                end else if (limit_q == '0) begin
                    // Zero-iteration loop: skip RUN, still report completion.
                    state_next = S_DONE;
                end else begin
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    // Abort wins over a simultaneous handshake; the counter
                    // keeps its partial value.
                    state_next = S_IDLE;
                end else begin
                    step_valid = 1'b1;
                    cnt_enable = step_ready;
                    if (step_ready && last_step) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef LOOP_SEQUENCER_LAST_EN
    assign step_last = step_valid & last_step;
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// tb/tb_loop_sequencer.sv - self-checking bench for loop_sequencer

module tb_loop_sequencer;

    localparam int WIDTH = 4;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_FIN   = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic             abort = 1'b0;
    logic             step_ready = 1'b0;
    logic [WIDTH-1:0] count = '0;
    logic             cnt_reset;
    logic             cnt_enable;
    logic             step_valid;
    logic             busy;
    logic             done;
`ifdef LOOP_SEQUENCER_LAST_EN
    logic             step_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model of loop progress: phase, latched limit, accepted handshakes.
    int ph    = P_IDLE;
    int m_lim = 0;
    int m_hs  = 0;

    // Observed pulse tallies, used for per-scenario literal expectations.
    int n_done = 0;
    int n_en   = 0;
    int n_sv   = 0;
    int n_clr  = 0;
    int n_last = 0;

    logic lat_clr = 1'b0;
    logic lat_en  = 1'b0;

    loop_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .limit      (limit),
        .abort      (abort),
        .step_ready (step_ready),
        .count      (count),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .step_valid (step_valid),
        .busy       (busy),
        .done       (done)
`ifdef LOOP_SEQUENCER_LAST_EN
        ,
        .step_last  (step_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Iteration counter environment: clear has priority over enable.
    always @(posedge clk) begin
        #1;
        if (lat_clr) count = '0;
        else if (lat_en) count = count + 4'd1;
    end

    // Compare process: mid-cycle, inputs stable, outputs settled.
    always @(negedge clk) begin
        int e_busy, e_clr, e_sv, e_en, e_done, e_last;
        lat_clr = cnt_reset;
        lat_en  = cnt_enable;
        n_done += int'(done);
        n_en   += int'(cnt_enable);
        n_sv   += int'(step_valid);
        n_clr  += int'(cnt_reset);
        if (!reset) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_clr", int'(cnt_reset), 0);
            chk("rst_en", int'(cnt_enable), 0);
            chk("rst_sv", int'(step_valid), 0);
            chk("rst_done", int'(done), 0);
            ph    = P_IDLE;
            m_lim = 0;
            m_hs  = 0;
        end else begin
            e_busy = int'(ph == P_CLEAR || ph == P_RUN);
            e_clr  = int'(ph == P_CLEAR);
            e_sv   = int'(ph == P_RUN && !abort);
            e_en   = int'(e_sv != 0 && step_ready);
            e_done = int'(ph == P_FIN);
            e_last = int'(e_sv != 0 && m_hs == m_lim - 1);
            chk("busy", int'(busy), e_busy);
            chk("cnt_reset", int'(cnt_reset), e_clr);
            chk("step_valid", int'(step_valid), e_sv);
            chk("cnt_enable", int'(cnt_enable), e_en);
            chk("done", int'(done), e_done);
`ifdef LOOP_SEQUENCER_LAST_EN
            n_last += int'(step_last);
            chk("step_last", int'(step_last), e_last);
`endif
            if (ph == P_RUN) chk("run_count", int'(count), m_hs);
            if (ph == P_FIN) chk("fin_count", int'(count), m_lim);

            case (ph)
                P_IDLE: if (start) begin
                    m_lim = int'(limit);
                    ph    = P_CLEAR;
                end
                P_CLEAR: begin
                    m_hs = 0;
                    if (abort) ph = P_IDLE;
                    else if (m_lim == 0) ph = P_FIN;
                    else ph = P_RUN;
                end
                P_RUN: begin
                    if (abort) ph = P_IDLE;
                    else if (step_ready) begin
                        m_hs++;
                        if (m_hs == m_lim) ph = P_FIN;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    task automatic tick(input logic st, input int lim, input logic ab, input logic rdy);
        start      = st;
        limit      = WIDTH'(lim);
        abort      = ab;
        step_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_done(input string name, input int maxc);
        int d0 = n_done;
        for (int i = 0; i < maxc; i++) begin
            tick(1'b0, 0, 1'b0, 1'b1);
            if (n_done != d0) break;
        end
        chk({name, "_timeout"}, int'(n_done != d0), 1);
        tick(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int d0, e0, s0, c0, l0;

        // Reset state
        repeat (3) tick(1'b0, 0, 1'b0, 1'b0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b1;
        tick(1'b0, 0, 1'b0, 1'b0);

        // Basic loop, limit 3
        d0 = n_done; e0 = n_en; c0 = n_clr;
        tick(1'b1, 3, 1'b0, 1'b1);
        run_until_done("basic", 20);
        chk("basic_count", int'(count), 3);
        chk("basic_en", n_en - e0, 3);
        chk("basic_clr", n_clr - c0, 1);
        chk("basic_done", n_done - d0, 1);

        // Backpressure, limit 2, ready 1,0,0,1
        d0 = n_done; e0 = n_en;
        tick(1'b1, 2, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b1);
        chk("bp_done_pending", n_done - d0, 0);
        tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b0);
        chk("bp_count", int'(count), 2);
        chk("bp_en", n_en - e0, 2);
        chk("bp_done", n_done - d0, 1);

        // Zero limit
        d0 = n_done; e0 = n_en; s0 = n_sv; c0 = n_clr;
        tick(1'b1, 0, 1'b0, 1'b1);
        repeat (4) tick(1'b0, 0, 1'b0, 1'b1);
        chk("zero_sv", n_sv - s0, 0);
        chk("zero_en", n_en - e0, 0);
        chk("zero_clr", n_clr - c0, 1);
        chk("zero_done", n_done - d0, 1);

        // Abort at count 5 with ready high, then a limit-1 loop
        d0 = n_done;
        tick(1'b1, 15, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 30 && count != 4'd5; i++) tick(1'b0, 0, 1'b0, 1'b1);
        chk("abort_reach5", int'(count), 5);
        tick(1'b0, 0, 1'b1, 1'b1);
        chk("abort_count", int'(count), 5);
        tick(1'b0, 0, 1'b0, 1'b1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count2", int'(count), 5);
        chk("abort_nodone", n_done - d0, 0);
        d0 = n_done;
        tick(1'b1, 1, 1'b0, 1'b1);
        run_until_done("after_abort", 10);
        chk("after_abort_count", int'(count), 1);
        chk("after_abort_done", n_done - d0, 1);

        // Max limit and last step
        d0 = n_done; e0 = n_en; l0 = n_last;
        tick(1'b1, 15, 1'b0, 1'b1);
        run_until_done("max", 40);
        chk("max_count", int'(count), 15);
        chk("max_en", n_en - e0, 15);
        chk("max_done", n_done - d0, 1);
`ifdef LOOP_SEQUENCER_LAST_EN
        chk("max_last", n_last - l0, 1);
`endif
        tick(1'b0, 0, 1'b0, 1'b0);
        chk("max_nowrap", int'(count), 15);

        // Asynchronous reset mid-RUN at count 2
        d0 = n_done;
        tick(1'b1, 6, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && count != 4'd2; i++) tick(1'b0, 0, 1'b0, 1'b1);
        chk("mid_busy_before", int'(busy), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_sv", int'(step_valid), 0);
        chk("async_en", int'(cnt_enable), 0);
        chk("async_clr", int'(cnt_reset), 0);
        tick(1'b0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b1);
        reset = 1'b1;
        repeat (4) tick(1'b0, 0, 1'b0, 1'b1);
        chk("async_idle_busy", int'(busy), 0);
        chk("async_nodone", n_done - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
